limb_step_scheduler: RTL and testbench

- Time-multiplexes one limb integration datapath (trq→acc→vel→pos, IEEE-754 single) across N_JOINT joints.
- Holds per-joint state (pos, vel, acc, trq) in register arrays, and on every integration tick sweeps all joints in index order.
- For each joint it issues operands to the datapath, waits DP_LAT cycles, then writes back results with position clamped to [0, POSMAX].
- Sits between the joint-level neuromuscular models and the shared limb arithmetic.

---
 rtl/limb_step_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_limb_step_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limb_step_scheduler.sv
// limb_step_scheduler
// Shares one limb integration datapath (trq -> acc -> vel -> pos, IEEE-754
// single) across N_JOINT joints. Every TICK_DIV enabled cycles the scheduler
// sweeps the joints in index order. For each joint it issues the stored
// operands, waits DP_LAT cycles and then writes the results back. The new
// position is clamped to [0, POSMAX] on the way in.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   enable                tick counter runs when high
//   load                  re-initialise all joints from pos/vel_default
//   pos_default/vel_default  values loaded on reset or load
//   dp_start/dp_idx       one-cycle issue strobe and the joint it belongs to
//   dp_pos/dp_vel/dp_acc  stored state of joint dp_idx
//   dp_*_res              datapath results, sampled in the write-back cycle
//   rd_idx, rd_*          combinational readback of joint rd_idx
//   busy                  a sweep is in progress
//   sweep_done            one-cycle pulse after the last joint is written
//   overrun               sticky: a tick arrived while a sweep was running
module limb_step_scheduler #(
    parameter int          N_JOINT  = 4,
    parameter int          IDX_W    = 2,
    parameter int          DP_LAT   = 2,
    parameter int          TICK_DIV = 1024,
    parameter logic [31:0] POSMAX   = 32'h4048F5C2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [31:0]      pos_default,
    input  logic [31:0]      vel_default,
    output logic             dp_start,
    output logic [IDX_W-1:0] dp_idx,
    output logic [31:0]      dp_pos,
    output logic [31:0]      dp_vel,
    output logic [31:0]      dp_acc,
    input  logic [31:0]      dp_pos_res,
    input  logic [31:0]      dp_vel_res,
    input  logic [31:0]      dp_acc_res,
    input  logic [31:0]      dp_trq_res,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_pos,
    output logic [31:0]      rd_vel,
    output logic [31:0]      rd_acc,
    output logic [31:0]      rd_trq,
    output logic             busy,
    output logic             sweep_done,
    output logic             overrun
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_W = $clog2(DP_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_JOINT - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(DP_LAT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Sign bit set (including -0, -Inf, negative NaN) maps to 0. For positive
    // values the magnitude bits order like unsigned integers, so +Inf and
    // positive NaN land above POSMAX and clamp to it.
    function automatic logic [31:0] clamp_pos(input logic [31:0] v);
        logic [31:0] r;
        if (v[31]) begin
            r = 32'h0000_0000;
        end else if (v[30:0] > POSMAX[30:0]) begin
            r = POSMAX;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [IDX_W-1:0]   dp_idx_r;
    logic [WAIT_W-1:0]  wait_r;
    logic               dp_start_r;
    logic               busy_r;
    logic               sweep_done_r;
    logic               overrun_r;
    logic               load_pend_r;
    logic [31:0]        pos_r [N_JOINT];
    logic [31:0]        vel_r [N_JOINT];
    logic [31:0]        acc_r [N_JOINT];
    logic [31:0]        trq_r [N_JOINT];

    logic               tick_s;
    logic [31:0]        pos_clamped_s;

    assign tick_s        = enable & (count_r == CNT_LAST);
    assign pos_clamped_s = clamp_pos(dp_pos_res);

    assign dp_start   = dp_start_r;
    assign dp_idx     = dp_idx_r;
    assign dp_pos     = pos_r[dp_idx_r];
    assign dp_vel     = vel_r[dp_idx_r];
    assign dp_acc     = acc_r[dp_idx_r];
    assign rd_pos     = pos_r[rd_idx];
    assign rd_vel     = vel_r[rd_idx];
    assign rd_acc     = acc_r[rd_idx];
    assign rd_trq     = trq_r[rd_idx];
    assign busy       = busy_r;
    assign sweep_done = sweep_done_r;
    assign overrun    = overrun_r;

    // Free-running integration tick counter, frozen while enable is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            if (count_r == CNT_LAST) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    // Sweep sequencer: issue / wait / write-back per joint, plus joint state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            dp_idx_r     <= {IDX_W{1'b0}};
            wait_r       <= {WAIT_W{1'b0}};
            dp_start_r   <= 1'b0;
            busy_r       <= 1'b0;
            sweep_done_r <= 1'b0;
            overrun_r    <= 1'b0;
            load_pend_r  <= 1'b0;
            for (int j = 0; j < N_JOINT; j++) begin
                pos_r[j] <= pos_default;
                vel_r[j] <= vel_default;
                acc_r[j] <= 32'h0000_0000;
                trq_r[j] <= 32'h0000_0000;
            end
        end else begin
            dp_start_r   <= 1'b0;
            sweep_done_r <= 1'b0;

            // Ticks during a sweep are dropped, not queued; loads are deferred.
            if (tick_s && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
            if (load && (state_r != IDLE)) begin
                load_pend_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (tick_s) begin
                        state_r    <= ISSUE;
                        dp_idx_r   <= {IDX_W{1'b0}};
                        busy_r     <= 1'b1;
                        dp_start_r <= 1'b1;
                        // Tick wins; the load is applied after this sweep.
                        if (load) begin
                            load_pend_r <= 1'b1;
                        end
                    end else if (load || load_pend_r) begin
                        load_pend_r <= 1'b0;
                        for (int j = 0; j < N_JOINT; j++) begin
                            pos_r[j] <= pos_default;
                            vel_r[j] <= vel_default;
                            acc_r[j] <= 32'h0000_0000;
                            trq_r[j] <= 32'h0000_0000;
                        end
                    end
                end
                ISSUE: begin
                    wait_r  <= WAIT_INIT;
                    state_r <= WAIT;
                end
                WAIT: begin
                    wait_r <= wait_r - WAIT_ONE;
                    if (wait_r == WAIT_ONE) begin
                        state_r <= WRITE;
                    end
                end
                WRITE: begin
                    pos_r[dp_idx_r] <= pos_clamped_s;
                    vel_r[dp_idx_r] <= dp_vel_res;
                    acc_r[dp_idx_r] <= dp_acc_res;
                    trq_r[dp_idx_r] <= dp_trq_res;
                    if (dp_idx_r == IDX_LAST) begin
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        sweep_done_r <= 1'b1;
                    end else begin
                        state_r    <= ISSUE;
                        dp_idx_r   <= dp_idx_r + IDX_W'(1);
                        dp_start_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_limb_step_scheduler.sv
module tb_limb_step_scheduler;

    localparam int N  = 4;
    localparam int L  = 2;
    localparam int TD = 32;
    localparam int IW = 2;
    localparam int S  = N * (L + 2);
    localparam int TD8 = 8;
    localparam logic [31:0] PMAX = 32'h4048F5C2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, enable, load, reset8;
    logic [31:0]   pos_default, vel_default;
    logic [31:0]   dp_pos_res, dp_vel_res, dp_acc_res, dp_trq_res;
    logic [IW-1:0] rd_idx;

    logic          dp_start, busy, sweep_done, overrun;
    logic [IW-1:0] dp_idx;
    logic [31:0]   dp_pos, dp_vel, dp_acc, rd_pos, rd_vel, rd_acc, rd_trq;

    logic          dp_start8, busy8, sweep_done8, overrun8;
    logic [IW-1:0] dp_idx8;
    logic [31:0]   dp_pos8, dp_vel8, dp_acc8, rd_pos8, rd_vel8, rd_acc8, rd_trq8;

    limb_step_scheduler #(.N_JOINT(N), .IDX_W(IW), .DP_LAT(L), .TICK_DIV(TD), .POSMAX(PMAX)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .pos_default(pos_default), .vel_default(vel_default),
        .dp_start(dp_start), .dp_idx(dp_idx), .dp_pos(dp_pos), .dp_vel(dp_vel), .dp_acc(dp_acc),
        .dp_pos_res(dp_pos_res), .dp_vel_res(dp_vel_res), .dp_acc_res(dp_acc_res), .dp_trq_res(dp_trq_res),
        .rd_idx(rd_idx), .rd_pos(rd_pos), .rd_vel(rd_vel), .rd_acc(rd_acc), .rd_trq(rd_trq),
        .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
    );

    // Short tick period so sweeps collide with ticks.
    limb_step_scheduler #(.N_JOINT(N), .IDX_W(IW), .DP_LAT(L), .TICK_DIV(TD8), .POSMAX(PMAX)) u_dut8 (
        .clk(clk), .reset(reset8), .enable(1'b1), .load(1'b0),
        .pos_default(pos_default), .vel_default(vel_default),
        .dp_start(dp_start8), .dp_idx(dp_idx8), .dp_pos(dp_pos8), .dp_vel(dp_vel8), .dp_acc(dp_acc8),
        .dp_pos_res(dp_pos_res), .dp_vel_res(dp_vel_res), .dp_acc_res(dp_acc_res), .dp_trq_res(dp_trq_res),
        .rd_idx(rd_idx), .rd_pos(rd_pos8), .rd_vel(rd_vel8), .rd_acc(rd_acc8), .rd_trq(rd_trq8),
        .busy(busy8), .sweep_done(sweep_done8), .overrun(overrun8)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_sw is the position inside a sweep: 0 = idle, 1..S = cycle of the
    // sweep. Each joint takes L+2 cycles: issue, L waits, write-back.
    logic [31:0] m_pos [N];
    logic [31:0] m_vel [N];
    logic [31:0] m_acc [N];
    logic [31:0] m_trq [N];
    int  m_cnt, m_sw;
    bit  m_done, m_ovr, m_lpend;
    bit  model_ok = 1'b0;
    int  m8_cnt, m8_sw;
    bit  m8_done, m8_ovr;

    function automatic logic [31:0] ref_clamp(input logic [31:0] v);
        logic [30:0] mag;
        mag = v[30:0];
        if (v[31] == 1'b1) return 32'h0000_0000;
        if (mag > PMAX[30:0]) return PMAX;
        return v;
    endfunction

    task automatic load_defaults();
        for (int i = 0; i < N; i++) begin
            m_pos[i] = pos_default;
            m_vel[i] = vel_default;
            m_acc[i] = 32'h0;
            m_trq[i] = 32'h0;
        end
    endtask

    task automatic model_step();
        bit tk;
        int j;
        if (reset == 1'b0) begin
            load_defaults();
            m_cnt = 0; m_sw = 0; m_done = 0; m_ovr = 0; m_lpend = 0;
        end else begin
            tk = (enable == 1'b1) && (m_cnt == TD - 1);
            if (enable == 1'b1) m_cnt = (m_cnt + 1) % TD;
            m_done = 0;
            if (m_sw == 0) begin
                if (tk) begin
                    m_sw = 1;
                    if (load == 1'b1) m_lpend = 1;
                end else if (load == 1'b1 || m_lpend) begin
                    load_defaults();
                    m_lpend = 0;
                end
            end else begin
                if (tk) m_ovr = 1;
                if (load == 1'b1) m_lpend = 1;
                j = (m_sw - 1) / (L + 2);
                if ((m_sw - 1) % (L + 2) == L + 1) begin
                    m_pos[j] = ref_clamp(dp_pos_res);
                    m_vel[j] = dp_vel_res;
                    m_acc[j] = dp_acc_res;
                    m_trq[j] = dp_trq_res;
                end
                if (m_sw == S) begin
                    m_sw = 0;
                    m_done = 1;
                end else begin
                    m_sw++;
                end
            end
        end
        model_ok = 1'b1;
    endtask

    task automatic model8_step();
        bit tk;
        if (reset8 == 1'b0) begin
            m8_cnt = 0; m8_sw = 0; m8_done = 0; m8_ovr = 0;
        end else begin
            tk = (m8_cnt == TD8 - 1);
            m8_cnt = (m8_cnt + 1) % TD8;
            m8_done = 0;
            if (m8_sw == 0) begin
                if (tk) m8_sw = 1;
            end else begin
                if (tk) m8_ovr = 1;
                if (m8_sw == S) begin
                    m8_sw = 0;
                    m8_done = 1;
                end else begin
                    m8_sw++;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int dmode = 0;
    logic [31:0] tbl_a [4];
    logic [31:0] tbl_b [4];
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    logic [31:0] specials [11];

    task automatic drive_res();
        int j;
        dp_vel_res = $urandom;
        dp_acc_res = $urandom;
        dp_trq_res = $urandom;
        j = (m_sw != 0) ? (m_sw - 1) / (L + 2) : 0;
        case (dmode)
            1:       dp_pos_res = tbl_a[j];
            2:       dp_pos_res = tbl_b[j];
            default: begin
                if ($urandom_range(0, 3) == 0) dp_pos_res = specials[$urandom_range(0, 10)];
                else dp_pos_res = $urandom;
            end
        endcase
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_step();
        model8_step();
        #1;
        drive_res();
    endtask

    task automatic wait_done(input int bound, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick_clk();
            if (sweep_done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk(nm, 32'(got), 32'd1);
    endtask

    task automatic wait_sw(input int target, input int bound, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick_clk();
            if (m_sw == target) begin
                got = 1'b1;
                break;
            end
        end
        chk(nm, 32'(got), 32'd1);
    endtask

    // ---------------- per-cycle compare against the model ----------------
    int cj;
    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy", 32'(busy), 32'(m_sw != 0));
            chk("dp_start", 32'(dp_start), 32'(m_sw != 0 && (m_sw - 1) % (L + 2) == 0));
            chk("sweep_done", 32'(sweep_done), 32'(m_done));
            chk("overrun", 32'(overrun), 32'(m_ovr));
            chk("rd_pos", rd_pos, m_pos[rd_idx]);
            chk("rd_vel", rd_vel, m_vel[rd_idx]);
            chk("rd_acc", rd_acc, m_acc[rd_idx]);
            chk("rd_trq", rd_trq, m_trq[rd_idx]);
            if (m_sw != 0) begin
                cj = (m_sw - 1) / (L + 2);
                chk("dp_idx", 32'(dp_idx), 32'(cj));
                chk("dp_pos", dp_pos, m_pos[cj]);
                chk("dp_vel", dp_vel, m_vel[cj]);
                chk("dp_acc", dp_acc, m_acc[cj]);
            end
            chk("busy8", 32'(busy8), 32'(m8_sw != 0));
            chk("dp_start8", 32'(dp_start8), 32'(m8_sw != 0 && (m8_sw - 1) % (L + 2) == 0));
            chk("sweep_done8", 32'(sweep_done8), 32'(m8_done));
            chk("overrun8", 32'(overrun8), 32'(m8_ovr));
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int nstart, done_k, n_start8, first_ovr8;
        tbl_a = '{32'hBF800000, 32'h80000000, 32'h40490FDB, 32'h4048F5C2};
        exp_a = '{32'h00000000, 32'h00000000, 32'h4048F5C2, 32'h4048F5C2};
        tbl_b = '{32'h3F800000, 32'h7FC00000, 32'hFF800000, 32'h4048F5C3};
        exp_b = '{32'h3F800000, 32'h4048F5C2, 32'h00000000, 32'h4048F5C2};
        specials = '{32'hBF800000, 32'h80000000, 32'h40490FDB, 32'h4048F5C2, 32'h3F800000,
                     32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h4048F5C3,
                     32'h4048F5C1};
        reset = 1'b0; reset8 = 1'b0; enable = 1'b0; load = 1'b0;
        pos_default = 32'h3F800000; vel_default = 32'h00000000;
        rd_idx = '0;
        dp_pos_res = 32'h0; dp_vel_res = 32'h0; dp_acc_res = 32'h0; dp_trq_res = 32'h0;

        // Reset state.
        repeat (3) tick_clk();
        reset = 1'b1;
        for (int j = 0; j < N; j++) begin
            rd_idx = IW'(j);
            tick_clk();
            chk("reset_pos", rd_pos, 32'h3F800000);
            chk("reset_vel", rd_vel, 32'h00000000);
            chk("reset_acc", rd_acc, 32'h00000000);
            chk("reset_trq", rd_trq, 32'h00000000);
        end
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ovr", 32'(overrun), 32'd0);

        // First sweep: issue timing and clamp table A. The tick cycle has
        // count 31, so the first issue follows the 32nd enabled edge.
        enable = 1'b1; reset8 = 1'b1; dmode = 1;
        nstart = 0; done_k = -1; n_start8 = 0; first_ovr8 = -1;
        for (int k = 1; k <= 48; k++) begin
            tick_clk();
            if (dp_start === 1'b1) begin
                chk("start_cycle", 32'(k), 32'(32 + 4 * nstart));
                chk("start_idx", 32'(dp_idx), 32'(nstart));
                nstart++;
            end
            if (sweep_done === 1'b1 && done_k < 0) done_k = k;
            if (dp_start8 === 1'b1) n_start8++;
            if (overrun8 === 1'b1 && first_ovr8 < 0) first_ovr8 = k;
        end
        chk("n_starts", 32'(nstart), 32'd4);
        chk("done_cycle", 32'(done_k), 32'd48);
        // Short-tick instance: sweeps start at 8 and 32 only; the tick at
        // count 15 lands mid-sweep and raises overrun on edge 16.
        chk("n_start8", 32'(n_start8), 32'd8);
        chk("ovr8_cycle", 32'(first_ovr8), 32'd16);

        dmode = 2;
        for (int j = 0; j < N; j++) begin
            rd_idx = IW'(j);
            tick_clk();
            chk("clamp_a", rd_pos, exp_a[j]);
        end
        wait_done(64, "sweep_b_timeout");
        dmode = 0;
        for (int j = 0; j < N; j++) begin
            rd_idx = IW'(j);
            tick_clk();
            chk("clamp_b", rd_pos, exp_b[j]);
        end

        // Load during joint 1's first wait cycle.
        wait_sw(L + 4, 80, "load_wait_timeout");
        pos_default = 32'h40000000; vel_default = 32'h3F000000; load = 1'b1;
        tick_clk();
        load = 1'b0;
        wait_done(40, "load_done_timeout");
        for (int j = 0; j < N; j++) begin
            rd_idx = IW'(j);
            tick_clk();
            chk("load_pos", rd_pos, 32'h40000000);
            chk("load_vel", rd_vel, 32'h3F000000);
            chk("load_acc", rd_acc, 32'h00000000);
            chk("load_trq", rd_trq, 32'h00000000);
        end

        // Reset during joint 2's wait aborts the sweep.
        wait_sw(2 * (L + 2) + 2, 80, "abort_wait_timeout");
        pos_default = 32'h3E800000; vel_default = 32'hBF800000; reset = 1'b0;
        tick_clk();
        reset = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_start", 32'(dp_start), 32'd0);
        for (int j = 0; j < N; j++) begin
            rd_idx = IW'(j);
            tick_clk();
            chk("abort_pos", rd_pos, 32'h3E800000);
            chk("abort_vel", rd_vel, 32'hBF800000);
        end

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 7) != 0);
            load   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 31) == 0) begin
                pos_default = $urandom;
                vel_default = $urandom;
            end
            rd_idx = IW'($urandom_range(0, N - 1));
            tick_clk();
        end
        load = 1'b0;
        tick_clk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
